// File: rtl/time_set_ctrl.sv
// Mode/set sequencer for the digital clock: RUN -> SET_HOUR -> SET_MIN.
// Optional idle auto-return to RUN is enabled with macro AUTO_EXIT_EN.
module time_set_ctrl #(
  parameter int TIMEOUT_TICKS = 10,
  parameter int TW            = 4
) (
  input  logic       clk_out,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       mode_pls,
  input  logic       up_pls,
  input  logic       down_pls,
  output logic [1:0] state,
  output logic       run_en,
  output logic       hour_inc,
  output logic       hour_dec,
  output logic       min_inc,
  output logic       min_dec,
  output logic       sec_clr,
  output logic [3:0] blink_mask
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    BAD      = 2'd3
  } state_t;

  state_t cur;
  logic   blink_phase;
  logic   expire;
  logic   btn;

  assign btn = mode_pls | up_pls | down_pls;

`ifdef AUTO_EXIT_EN
  logic [TW-1:0] cnt;

  assign expire = tick && (cnt == TW'(TIMEOUT_TICKS - 1));

  // Idle ticks since the last button or state entry.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cur == RUN || cur == BAD || btn || expire) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign expire     = 1'b0;
  assign unused_cfg = ^{TW, TIMEOUT_TICKS, btn};
`endif

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= RUN;
      blink_phase <= 1'b1;
      hour_inc    <= 1'b0;
      hour_dec    <= 1'b0;
      min_inc     <= 1'b0;
      min_dec     <= 1'b0;
      sec_clr     <= 1'b0;
    end else begin
      hour_inc <= 1'b0;
      hour_dec <= 1'b0;
      min_inc  <= 1'b0;
      min_dec  <= 1'b0;
      sec_clr  <= 1'b0;
      unique case (cur)
        RUN: begin
          blink_phase <= 1'b1;
          if (mode_pls) cur <= SET_HOUR;
        end
        SET_HOUR, SET_MIN: begin
          if (mode_pls) begin
            cur         <= (cur == SET_HOUR) ? SET_MIN : RUN;
            sec_clr     <= (cur == SET_MIN);
            blink_phase <= 1'b1;
          end else if (up_pls || down_pls) begin
            // Both buttons at once: no step, but still activity.
            blink_phase <= 1'b1;
            hour_inc    <= (cur == SET_HOUR) & up_pls & ~down_pls;
            hour_dec    <= (cur == SET_HOUR) & down_pls & ~up_pls;
            min_inc     <= (cur == SET_MIN) & up_pls & ~down_pls;
            min_dec     <= (cur == SET_MIN) & down_pls & ~up_pls;
          end else if (expire) begin
            cur         <= RUN;
            sec_clr     <= 1'b1;
            blink_phase <= 1'b1;
          end else if (tick) begin
            blink_phase <= ~blink_phase;
          end
        end
        BAD: begin
          cur         <= RUN;
          blink_phase <= 1'b1;
        end
      endcase
    end
  end

  assign state  = cur;
  assign run_en = (cur == RUN);

  always_comb begin
    blink_mask = 4'b0000;
    unique case (1'b1)
      (cur == SET_HOUR && !blink_phase): blink_mask = 4'b1100;
      (cur == SET_MIN && !blink_phase):  blink_mask = 4'b0011;
      default:                           blink_mask = 4'b0000;
    endcase
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: vector table, hand sequences, random vs model.
// Honors AUTO_EXIT_EN the same way as the design.
module tb_time_set_ctrl;

  localparam int TIMEOUT = 10;

  logic       clk_out = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       mode_pls = 1'b0;
  logic       up_pls = 1'b0;
  logic       down_pls = 1'b0;
  logic [1:0] state;
  logic       run_en;
  logic       hour_inc;
  logic       hour_dec;
  logic       min_inc;
  logic       min_dec;
  logic       sec_clr;
  logic [3:0] blink_mask;

  int checks = 0;
  int errors = 0;

  int   m_state;
  bit   m_phase;
  int   m_cnt;
  logic m_hi, m_hd, m_mi, m_md, m_sc;

  always #5 clk_out = ~clk_out;

  time_set_ctrl dut (
    .clk_out(clk_out),
    .rst_n(rst_n),
    .tick(tick),
    .mode_pls(mode_pls),
    .up_pls(up_pls),
    .down_pls(down_pls),
    .state(state),
    .run_en(run_en),
    .hour_inc(hour_inc),
    .hour_dec(hour_dec),
    .min_inc(min_inc),
    .min_dec(min_dec),
    .sec_clr(sec_clr),
    .blink_mask(blink_mask)
  );

  typedef struct {
    logic       t, m, u, d;
    int         st;
    logic       hi, hd, mi, md, sc;
    logic [3:0] mask;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [11:0] obs();
    return {state, run_en, hour_inc, hour_dec,
            min_inc, min_dec, sec_clr, blink_mask};
  endfunction

  function automatic logic [11:0] mk(int st, logic hi, logic hd,
                                     logic mi, logic md, logic sc,
                                     logic [3:0] mask);
    logic [1:0] s2;
    s2 = 2'(st);
    return {s2, (st == 0), hi, hd, mi, md, sc, mask};
  endfunction

  task automatic check(string name, logic [11:0] act, logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_phase = 1;
    m_cnt   = 0;
    {m_hi, m_hd, m_mi, m_md, m_sc} = '0;
  endtask

  // Spec rules applied to one cycle of inputs.
  task automatic model_step(logic t, logic m, logic u, logic d);
    {m_hi, m_hd, m_mi, m_md, m_sc} = '0;
    if (m_state == 0) begin
      if (m) m_state = 1;
      m_phase = 1;
      m_cnt   = 0;
    end else if (m) begin
      m_sc    = (m_state == 2);
      m_state = (m_state == 1) ? 2 : 0;
      m_phase = 1;
      m_cnt   = 0;
    end else if (u || d) begin
      if (u != d) begin
        if (m_state == 1) begin
          m_hi = u;
          m_hd = d;
        end else begin
          m_mi = u;
          m_md = d;
        end
      end
      m_phase = 1;
      m_cnt   = 0;
    end else if (t) begin
      m_phase = !m_phase;
      m_cnt   = m_cnt + 1;
`ifdef AUTO_EXIT_EN
      if (m_cnt >= TIMEOUT) begin
        m_state = 0;
        m_sc    = 1;
        m_cnt   = 0;
        m_phase = 1;
      end
`endif
    end
  endtask

  function automatic logic [11:0] model_vec();
    logic [3:0] mask;
    mask = 4'b0000;
    if (!m_phase && m_state == 1) mask = 4'b1100;
    if (!m_phase && m_state == 2) mask = 4'b0011;
    return mk(m_state, m_hi, m_hd, m_mi, m_md, m_sc, mask);
  endfunction

  task automatic step(string name, logic t, logic m, logic u, logic d);
    tick     = t;
    mode_pls = m;
    up_pls   = u;
    down_pls = d;
    @(posedge clk_out);
    #1;
    model_step(t, m, u, d);
    check(name, obs(), model_vec());
  endtask

  task automatic idle();
    step("idle", 0, 0, 0, 0);
  endtask

  initial begin
    //            t  m  u  d  st hi hd mi md sc mask
    tbl.push_back('{0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0000});
    tbl.push_back('{0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 4'b0000});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0000});
    tbl.push_back('{0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 4'b0000});
    tbl.push_back('{0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 4'b0000});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 4'b0000});
    tbl.push_back('{0, 1, 1, 0, 2, 0, 0, 0, 0, 0, 4'b0000});
    tbl.push_back('{0, 0, 1, 1, 2, 0, 0, 0, 0, 0, 4'b0000});
    tbl.push_back('{0, 0, 1, 0, 2, 0, 0, 1, 0, 0, 4'b0000});
    tbl.push_back('{0, 0, 0, 1, 2, 0, 0, 0, 1, 0, 4'b0000});
    tbl.push_back('{1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 4'b0011});
    tbl.push_back('{1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 4'b0000});
    tbl.push_back('{1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 4'b0011});
    tbl.push_back('{0, 0, 0, 1, 2, 0, 0, 0, 1, 0, 4'b0000});
    tbl.push_back('{1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 4'b0011});
    tbl.push_back('{0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 4'b0000});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0000});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000});
    tbl.push_back('{0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0000});
    tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'b1100});
    tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0000});
    tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'b1100});
    tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0000});
    tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'b1100});
    tbl.push_back('{1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 4'b0000});
    tbl.push_back('{0, 1, 0, 0, 2, 0, 0, 0, 0, 0, 4'b0000});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000});

    model_reset();
    #12;
    check("reset_state", obs(), mk(0, 0, 0, 0, 0, 0, 4'b0000));
    @(negedge clk_out);
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) begin
      step("idle_run", (i % 2) == 0, 0, 0, 0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      tick     = tbl[i].t;
      mode_pls = tbl[i].m;
      up_pls   = tbl[i].u;
      down_pls = tbl[i].d;
      @(posedge clk_out);
      #1;
      model_step(tbl[i].t, tbl[i].m, tbl[i].u, tbl[i].d);
      check($sformatf("table_%0d", i), obs(),
            mk(tbl[i].st, tbl[i].hi, tbl[i].hd, tbl[i].mi,
               tbl[i].md, tbl[i].sc, tbl[i].mask));
      check($sformatf("table_model_%0d", i), obs(), model_vec());
    end

    step("enter_hour", 0, 1, 0, 0);
    step("enter_min", 0, 1, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step("timeout_tick", 1, 0, 0, 0);
      if (i == 10) begin
`ifdef AUTO_EXIT_EN
        check("timeout_exit", obs(), mk(0, 0, 0, 0, 0, 1, 4'b0000));
`else
        check("timeout_hold", obs(), mk(2, 0, 0, 0, 0, 0, 4'b0000));
`endif
      end
      idle();
    end

    if (m_state != 0) step("leave", 0, 1, 0, 0);
    step("enter_hour2", 0, 1, 0, 0);
    step("enter_min2", 0, 1, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step("late_tick", 1, 0, i == 9, 0);
      if (i == 9)
        check("up_at_tick9", obs(), mk(2, 0, 0, 1, 0, 0, 4'b0000));
      if (i == 10)
        check("no_exit_tick10", obs(), mk(2, 0, 0, 0, 0, 0, 4'b0011));
      idle();
    end

`ifndef AUTO_EXIT_EN
    for (int i = 0; i < 30; i++) begin
      step("long_tick", 1, 0, 0, 0);
      idle();
    end
    check("hold_30_ticks", {10'b0, state}, 12'd2);
`endif

    if (m_state != 0) step("leave2", 0, 1, 0, 0);
    step("rst_enter", 0, 1, 0, 0);
    step("rst_up", 0, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", obs(), mk(0, 0, 0, 0, 0, 0, 4'b0000));
    model_reset();
    @(negedge clk_out);
    rst_n = 1'b1;
    idle();

    for (int i = 0; i < 3000; i++) begin
      int rate;
      rate = (i < 1500) ? 5 : 60;
      step("random",
           $urandom_range(3) == 0,
           $urandom_range(rate + 10) == 0,
           $urandom_range(rate) == 0,
           $urandom_range(rate) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
